ps2_key_rx: RTL and testbench

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_key_rx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronise and filter the lines, deframe 11-bit frames,
// fold E0/F0 prefixes into events, queue events in a FWFT FIFO, track arrow keys.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic       iCLK_50,
    input  logic       iRST,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic [3:0] key_held,
    output logic       frame_err,
    output logic       ovf
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

    // Index 0 carries PS2_CLK, index 1 carries PS2_DAT.
    logic [1:0]      r_sync1, r_sync2, r_filt;
    logic [7:0]      r_fcnt [2];
    logic            r_clk_prev;
    logic            w_fall, w_bit;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_bitcnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [9:0]      r_shift;
    logic            r_ext_pend, r_brk_pend;
    logic            w_err, w_push, w_set_ext, w_set_brk, w_clr_pend;
    logic            w_par_odd, w_par_ok;
    logic [9:0]      w_ev;

    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_full, w_pop, w_wr;
    logic [9:0]      w_head;
    logic            r_frame_err, r_ovf;

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_filt     <= '1;
            r_clk_prev <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) r_fcnt[i] <= '0;
        end else begin
            r_sync1    <= {PS2_DAT, PS2_CLK};
            r_sync2    <= r_sync1;
            r_clk_prev <= r_filt[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_filt[i]) begin
                    if (r_fcnt[i] == 8'(FILTER_LEN - 1)) begin
                        r_filt[i] <= r_sync2[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + 8'd1;
                    end
                end else begin
                    r_fcnt[i] <= '0;
                end
            end
        end
    end

    assign w_fall    = r_clk_prev & ~r_filt[0];
    assign w_bit     = r_filt[1];
    assign w_par_odd = ^r_shift[8:0];
`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok  = w_par_odd;
`else
    // Parity is still shifted in; it just never vetoes a frame.
    assign w_par_ok  = w_par_odd | 1'b1;
`endif
    assign w_ev = {r_ext_pend, r_brk_pend, r_shift[7:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_push      = 1'b0;
        w_set_ext   = 1'b0;
        w_set_brk   = 1'b0;
        w_clr_pend  = 1'b0;
        case (r_state)
            S_IDLE: if (w_fall && !w_bit) w_state_nxt = S_RECV;
            S_RECV: begin
                if (w_fall && r_bitcnt == 4'd9) begin
                    w_state_nxt = S_CHECK;
                end else if (!w_fall && r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                if (!r_shift[9] || !w_par_ok) begin
                    w_err      = 1'b1;
                    w_clr_pend = 1'b1;
                end else if (r_shift[7:0] == 8'hE0) begin
                    w_set_ext = 1'b1;
                end else if (r_shift[7:0] == 8'hF0) begin
                    w_set_brk = 1'b1;
                end else begin
                    w_push     = 1'b1;
                    w_clr_pend = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_to_cnt    <= '0;
            r_shift     <= '0;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
            key_held    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_err <= w_err;
            if (r_state == S_RECV) begin
                if (w_fall) begin
                    r_shift  <= {w_bit, r_shift[9:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end else begin
                r_bitcnt <= '0;
                r_to_cnt <= '0;
            end
            if (w_clr_pend) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
            if (w_set_ext) r_ext_pend <= 1'b1;
            if (w_set_brk) r_brk_pend <= 1'b1;
            if (w_push && r_ext_pend) begin
                case (r_shift[7:0])
                    8'h75:   key_held[0] <= !r_brk_pend;
                    8'h72:   key_held[1] <= !r_brk_pend;
                    8'h6B:   key_held[2] <= !r_brk_pend;
                    8'h74:   key_held[3] <= !r_brk_pend;
                    default: ;
                endcase
            end
        end
    end

    assign ev_valid = (r_count != '0);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_pop    = ev_valid && ev_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr     = w_push && (!w_full || w_pop);

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= w_push && w_full && !w_pop;
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_ev;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign ev_code   = ev_valid ? w_head[7:0] : '0;
    assign ev_brk    = ev_valid ? w_head[8]   : 1'b0;
    assign ev_ext    = ev_valid ? w_head[9]   : 1'b0;
    assign frame_err = r_frame_err;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: bit-banged PS/2 frames, logged events and pulses
// compared against hand-computed values.
module tb_ps2_key_rx;
    localparam int unsigned TO    = 2000;
    localparam int unsigned DEPTH = 8;
    localparam int          HALF  = 20;

    logic       iCLK_50 = 1'b0;
    logic       iRST    = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic       ev_ready = 1'b1;
    logic       ev_valid, ev_ext, ev_brk, frame_err, ovf;
    logic [7:0] ev_code;
    logic [3:0] key_held;

    int n_vec = 0, n_err = 0;
    int n_ev = 0, n_vcyc = 0, n_ferr = 0, n_ovf = 0;
    int b_ev, b_vcyc, b_ferr, b_ovf;
    logic [9:0] ev_log [64];

    ps2_key_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .iCLK_50(iCLK_50), .iRST(iRST), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_ext(ev_ext), .ev_brk(ev_brk), .key_held(key_held),
        .frame_err(frame_err), .ovf(ovf)
    );

    always #5 iCLK_50 = ~iCLK_50;

    always @(negedge iCLK_50) begin
        if (!iRST) begin
            if (frame_err) n_ferr++;
            if (ovf) n_ovf++;
            if (ev_valid) n_vcyc++;
            if (ev_valid && ev_ready && n_ev < 64) begin
                ev_log[n_ev] = {ev_ext, ev_brk, ev_code};
                n_ev++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge iCLK_50);
        #2;
    endtask

    task automatic mark();
        b_ev = n_ev; b_vcyc = n_vcyc; b_ferr = n_ferr; b_ovf = n_ovf;
    endtask

    // Start, 8 data LSB first, odd parity, stop; glitch adds 1-cycle pulses on PS2_CLK.
    task automatic send_frame(input logic [7:0] b, input bit par_inv, input int nbits, input bit glitch);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ par_inv, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = f[i];
            if (glitch) begin
                wait_cyc(HALF / 2); PS2_CLK = 1'b0; wait_cyc(1); PS2_CLK = 1'b1;
                wait_cyc(HALF - HALF / 2 - 1);
            end else begin
                wait_cyc(HALF);
            end
            PS2_CLK = 1'b0;
            if (glitch) begin
                wait_cyc(HALF / 2); PS2_CLK = 1'b1; wait_cyc(1); PS2_CLK = 1'b0;
                wait_cyc(HALF - HALF / 2 - 1);
            end else begin
                wait_cyc(HALF);
            end
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    initial begin
        wait_cyc(3);
        PS2_CLK = 1'b0; PS2_DAT = 1'b0;
        wait_cyc(3);
        PS2_CLK = 1'b1; PS2_DAT = 1'b1;
        wait_cyc(2);
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_code", 32'(ev_code), 32'h00);
        chk("rst_flags", 32'({ev_ext, ev_brk}), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        chk("rst_pulses", 32'({frame_err, ovf}), 32'd0);
        iRST = 1'b0;
        wait_cyc(30);
        chk("rst_ignore_ps2", 32'(n_ferr + n_ev), 32'd0);

        mark();
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        chk("basic_count", 32'(n_ev - b_ev), 32'd1);
        chk("basic_event", 32'(ev_log[b_ev]), 32'h01C);
        chk("basic_vcyc", 32'(n_vcyc - b_vcyc), 32'd1);
        chk("basic_ferr", 32'(n_ferr - b_ferr), 32'd0);

        mark();
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'h75, 1'b0, 11, 1'b0);
        chk("ext_make_event", 32'(ev_log[b_ev]), 32'h275);
        chk("ext_make_held", 32'(key_held), 32'h1);
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        send_frame(8'h75, 1'b0, 11, 1'b0);
        chk("ext_brk_count", 32'(n_ev - b_ev), 32'd2);
        chk("ext_brk_event", 32'(ev_log[b_ev + 1]), 32'h375);
        chk("ext_brk_held", 32'(key_held), 32'h0);

        mark();
        ev_ready = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) send_frame(8'h16, 1'b0, 11, 1'b0);
        chk("ovf_pulses", 32'(n_ovf - b_ovf), 32'd1);
        chk("ovf_no_pop", 32'(n_ev - b_ev), 32'd0);
        chk("ovf_head_valid", 32'(ev_valid), 32'd1);
        chk("ovf_head_code", 32'(ev_code), 32'h16);
        ev_ready = 1'b1;
        wait_cyc(20);
        chk("drain_count", 32'(n_ev - b_ev), 32'(DEPTH));
        for (int k = 0; k < DEPTH; k++) chk("drain_event", 32'(ev_log[b_ev + k]), 32'h016);
        chk("drain_empty", 32'(ev_valid), 32'd0);

        mark();
        send_frame(8'h1C, 1'b1, 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_ferr", 32'(n_ferr - b_ferr), 32'd1);
        chk("par_count", 32'(n_ev - b_ev), 32'd0);
`else
        chk("par_ferr", 32'(n_ferr - b_ferr), 32'd0);
        chk("par_count", 32'(n_ev - b_ev), 32'd1);
        chk("par_event", 32'(ev_log[b_ev]), 32'h01C);
`endif

        mark();
        send_frame(8'h29, 1'b0, 5, 1'b0);
        wait_cyc(TO + 2);
        chk("to_ferr", 32'(n_ferr - b_ferr), 32'd1);
        chk("to_count", 32'(n_ev - b_ev), 32'd0);
        send_frame(8'h29, 1'b0, 11, 1'b0);
        chk("to_recover_count", 32'(n_ev - b_ev), 32'd1);
        chk("to_recover_event", 32'(ev_log[b_ev]), 32'h029);

        mark();
        send_frame(8'h5A, 1'b0, 4, 1'b0);
        iRST = 1'b1;
        wait_cyc(3);
        chk("midrst_valid", 32'(ev_valid), 32'd0);
        iRST = 1'b0;
        wait_cyc(30);
        send_frame(8'h29, 1'b0, 11, 1'b0);
        chk("midrst_count", 32'(n_ev - b_ev), 32'd1);
        chk("midrst_event", 32'(ev_log[b_ev]), 32'h029);
        chk("midrst_ferr", 32'(n_ferr - b_ferr), 32'd0);

        mark();
        send_frame(8'h1C, 1'b0, 11, 1'b1);
        chk("glitch_count", 32'(n_ev - b_ev), 32'd1);
        chk("glitch_event", 32'(ev_log[b_ev]), 32'h01C);
        chk("glitch_ferr", 32'(n_ferr - b_ferr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
